// File: rtl/scan_ctrl_pkg.sv
// scan_ctrl_pkg: shared definitions for the scan shift controller.
//   DEFAULT_CHAIN_LEN : default number of flops in the driven scan chain
//   state_t           : controller FSM states
package scan_ctrl_pkg;

  localparam int unsigned DEFAULT_CHAIN_LEN = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_IN,
    ST_CAPTURE,
    ST_SHIFT_OUT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/scan_bit_counter.sv
// scan_bit_counter: saturating shift-bit counter, 0 .. LEN-1.
//   clk      : clock, rising edge
//   clr_     : asynchronous active-low reset
//   i_clear  : synchronous clear to 0 (priority over enable)
//   i_enable : advance by one per cycle; holds at terminal count
//   o_tc     : high while the count equals LEN-1
module scan_bit_counter
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned LEN = DEFAULT_CHAIN_LEN
) (
  input  logic clk,
  input  logic clr_,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  localparam int unsigned W = $clog2(LEN);
  localparam logic [W-1:0] TC = W'(LEN - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != TC)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_tc = (r_count == TC);

endmodule

// File: rtl/scan_shift_ctrl.sv
// scan_shift_ctrl: loads a pattern into a scan chain, optionally pulses a
// functional capture and unloads the chain, then returns the unloaded data.
//   clk, clr_              : clock (rising edge), async active-low reset
//   req_valid/req_ready    : pattern request handshake
//   req_data, req_capture  : pattern (bit 0 shifted first), capture select
//   scan_se, scan_si       : chain scan enable and serial input (registered)
//   scan_so                : chain serial output
//   cap_pulse              : one-cycle capture strobe (registered)
//   rsp_valid/rsp_ready    : result handshake
//   rsp_data               : unloaded chain contents, first bit out at bit 0
//   busy                   : high whenever the FSM is not idle
module scan_shift_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = DEFAULT_CHAIN_LEN
) (
  input  logic                 clk,
  input  logic                 clr_,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CHAIN_LEN-1:0] req_data,
  input  logic                 req_capture,
  output logic                 scan_se,
  output logic                 scan_si,
  input  logic                 scan_so,
  output logic                 cap_pulse,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_data,
  output logic                 busy
);

  state_t               r_state;
  state_t               w_state_n;
  logic [CHAIN_LEN-1:0] r_sr;
  logic [CHAIN_LEN-1:0] w_sr_n;
  logic                 r_capture;
  logic                 w_capture_n;
  logic                 r_req_ready;
  logic                 r_scan_se;
  logic                 r_scan_si;
  logic                 r_cap_pulse;
  logic                 r_rsp_valid;
  logic                 w_tc;
  logic                 w_shifting;
  logic                 w_cnt_clear;

  assign w_shifting  = (r_state == ST_SHIFT_IN) || (r_state == ST_SHIFT_OUT);
  assign w_cnt_clear = !w_shifting;

  scan_bit_counter #(
    .LEN (CHAIN_LEN)
  ) u_bit_counter (
    .clk      (clk),
    .clr_     (clr_),
    .i_clear  (w_cnt_clear),
    .i_enable (w_shifting),
    .o_tc     (w_tc)
  );

  always_comb begin
    w_state_n   = r_state;
    w_sr_n      = r_sr;
    w_capture_n = r_capture;
    case (r_state)
      ST_IDLE: begin
        if (req_valid && r_req_ready) begin
          w_state_n   = ST_SHIFT_IN;
          w_sr_n      = req_data;
          w_capture_n = req_capture;
        end
      end
      ST_SHIFT_IN: begin
        w_sr_n = {scan_so, r_sr[CHAIN_LEN-1:1]};
        if (w_tc) begin
          w_state_n = r_capture ? ST_CAPTURE : ST_RESP;
        end
      end
      ST_CAPTURE: begin
        w_state_n = ST_SHIFT_OUT;
      end
      ST_SHIFT_OUT: begin
        w_sr_n = {scan_so, r_sr[CHAIN_LEN-1:1]};
        if (w_tc) begin
          w_state_n = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_n = ST_IDLE;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  // Registered outputs are decoded from the next state / next shift value so
  // they line up with the state they belong to, without combinational glitches.
  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      r_state     <= ST_IDLE;
      r_sr        <= '0;
      r_capture   <= 1'b0;
      r_req_ready <= 1'b0;
      r_scan_se   <= 1'b0;
      r_scan_si   <= 1'b0;
      r_cap_pulse <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_sr        <= w_sr_n;
      r_capture   <= w_capture_n;
      r_req_ready <= (w_state_n == ST_IDLE);
      r_scan_se   <= (w_state_n == ST_SHIFT_IN) || (w_state_n == ST_SHIFT_OUT);
      r_scan_si   <= (w_state_n == ST_SHIFT_IN) ? w_sr_n[0] : 1'b0;
      r_cap_pulse <= (w_state_n == ST_CAPTURE);
      r_rsp_valid <= (w_state_n == ST_RESP);
    end
  end

  assign req_ready = r_req_ready;
  assign scan_se   = r_scan_se;
  assign scan_si   = r_scan_si;
  assign cap_pulse = r_cap_pulse;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_sr;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_scan_shift_ctrl.sv
// tb_scan_shift_ctrl: drives scan_shift_ctrl (CHAIN_LEN=8) against an 8-flop
// chain model; expectations follow from the chain behaviour and transaction
// rules (rsp = old chain, or inverted pattern after capture).
module tb_scan_shift_ctrl;

  logic       clk = 1'b0;
  logic       clr_;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_data;
  logic       req_capture;
  logic       scan_se;
  logic       scan_si;
  logic       scan_so;
  logic       cap_pulse;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       busy;

  logic [7:0] chain;
  logic       chain_load;
  logic [7:0] chain_load_val;

  int n_cmp;
  int n_err;

  always #5 clk = ~clk;

  scan_shift_ctrl #(
    .CHAIN_LEN (8)
  ) dut (
    .clk         (clk),
    .clr_        (clr_),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .req_capture (req_capture),
    .scan_se     (scan_se),
    .scan_si     (scan_si),
    .scan_so     (scan_so),
    .cap_pulse   (cap_pulse),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .busy        (busy)
  );

  // Chain model: head takes scan_si at bit 7, tail is bit 0; capture inverts.
  always @(posedge clk) begin
    if (chain_load) chain <= chain_load_val;
    else if (scan_se) chain <= {scan_si, chain[7:1]};
    else if (cap_pulse) chain <= ~chain;
  end
  assign scan_so = chain[0];

  task automatic set_chain(input logic [7:0] v);
    @(negedge clk);
    chain_load_val = v;
    chain_load = 1'b1;
    @(negedge clk);
    chain_load = 1'b0;
  endtask

  // Runs one transaction and reports what was observed; callers compare.
  task automatic do_txn(input logic [7:0] data, input logic cap, input int stall,
                        output logic [7:0] o_rsp, output int o_busy,
                        output logic [31:0] o_si, output int o_se_n,
                        output int o_caps, output int o_cap_at,
                        output int o_stalls, output int o_bad,
                        output logic o_ready_after, output logic o_to);
    int guard;
    int stall_left;
    logic seen_rsp;
    logic done;
    logic [7:0] held;
    o_rsp = '0; o_busy = 0; o_si = '0; o_se_n = 0; o_caps = 0; o_cap_at = -1;
    o_stalls = 0; o_bad = 0; o_ready_after = 1'b0; o_to = 1'b0;
    held = '0;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      o_to = 1'b1;
      return;
    end
    req_valid = 1'b1; req_data = data; req_capture = cap; rsp_ready = 1'b0;
    stall_left = stall; done = 1'b0; seen_rsp = 1'b0; guard = 0;
    while (!done && guard < 200) begin
      @(negedge clk);
      guard++;
      req_valid = 1'b0;
      if (scan_se) begin
        if (o_se_n < 32) o_si[o_se_n] = scan_si;
        o_se_n++;
      end
      if (cap_pulse) begin
        o_caps++;
        o_cap_at = o_se_n;
        if (scan_se) o_bad++;
      end
      if (rsp_valid) begin
        if (!seen_rsp) held = rsp_data;
        else if (rsp_data !== held) o_bad++;
        seen_rsp = 1'b1;
        if (req_ready) o_bad++;
        if (stall_left > 0) begin
          stall_left--;
          rsp_ready = 1'b0;
          o_stalls++;
        end else begin
          rsp_ready = 1'b1;
          o_rsp = rsp_data;
          done = 1'b1;
        end
      end else if (seen_rsp) begin
        o_bad++;
      end
      if (busy && !(rsp_valid && !rsp_ready)) o_busy++;
    end
    if (!done) o_to = 1'b1;
    @(negedge clk);
    o_ready_after = req_ready;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    clr_ = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({req_ready, scan_se, scan_si, cap_pulse, rsp_valid, busy, rsp_data} !== 14'h0) begin
      n_err++;
      $display("FAIL reset_outputs got %b exp all zero",
               {req_ready, scan_se, scan_si, cap_pulse, rsp_valid, busy, rsp_data});
    end
    clr_ = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_ready got %b exp 0", req_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_first_edge_ready got %b exp 1", req_ready);
    end
  endtask

  task automatic test_load_no_capture();
    logic [7:0] rsp; logic [31:0] si; logic rdy, to;
    int bsy, se_n, caps, cap_at, stalls, bad;
    set_chain(8'hA5);
    do_txn(8'h3C, 1'b0, 0, rsp, bsy, si, se_n, caps, cap_at, stalls, bad, rdy, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL load_timeout got %b exp 0", to); end
    n_cmp++; if (rsp !== 8'hA5) begin n_err++; $display("FAIL load_rsp got %h exp a5", rsp); end
    n_cmp++; if (se_n != 8) begin n_err++; $display("FAIL load_se_cycles got %0d exp 8", se_n); end
    n_cmp++; if (si !== 32'h0000_003C) begin n_err++; $display("FAIL load_si_seq got %h exp 3c", si); end
    n_cmp++; if (caps != 0) begin n_err++; $display("FAIL load_caps got %0d exp 0", caps); end
    n_cmp++; if (bsy != 9) begin n_err++; $display("FAIL load_busy got %0d exp 9", bsy); end
    n_cmp++; if (rdy !== 1'b1) begin n_err++; $display("FAIL load_ready_after got %b exp 1", rdy); end
    n_cmp++; if (chain !== 8'h3C) begin n_err++; $display("FAIL load_chain got %h exp 3c", chain); end
  endtask

  task automatic test_capture();
    logic [7:0] rsp; logic [31:0] si; logic rdy, to;
    int bsy, se_n, caps, cap_at, stalls, bad;
    set_chain(8'h5E);
    do_txn(8'h0F, 1'b1, 0, rsp, bsy, si, se_n, caps, cap_at, stalls, bad, rdy, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL cap_timeout got %b exp 0", to); end
    n_cmp++; if (rsp !== 8'hF0) begin n_err++; $display("FAIL cap_rsp got %h exp f0", rsp); end
    n_cmp++; if (se_n != 16) begin n_err++; $display("FAIL cap_se_cycles got %0d exp 16", se_n); end
    n_cmp++; if (si !== 32'h0000_000F) begin n_err++; $display("FAIL cap_si_seq got %h exp 0000000f", si); end
    n_cmp++; if (caps != 1) begin n_err++; $display("FAIL cap_pulses got %0d exp 1", caps); end
    n_cmp++; if (cap_at != 8) begin n_err++; $display("FAIL cap_position got %0d exp 8", cap_at); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL cap_protocol got %0d exp 0", bad); end
    n_cmp++; if (bsy != 18) begin n_err++; $display("FAIL cap_busy got %0d exp 18", bsy); end
    n_cmp++; if (chain !== 8'h00) begin n_err++; $display("FAIL cap_chain got %h exp 00", chain); end
  endtask

  task automatic test_backpressure();
    logic [7:0] rsp, v, d; logic [31:0] si; logic rdy, to;
    int bsy, se_n, caps, cap_at, stalls, bad;
    v = 8'($urandom); d = 8'($urandom);
    set_chain(v);
    do_txn(d, 1'b0, 5, rsp, bsy, si, se_n, caps, cap_at, stalls, bad, rdy, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL bp_timeout got %b exp 0", to); end
    n_cmp++; if (stalls != 5) begin n_err++; $display("FAIL bp_stalls got %0d exp 5", stalls); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL bp_stable got %0d violations exp 0", bad); end
    n_cmp++; if (rsp !== v) begin n_err++; $display("FAIL bp_rsp got %h exp %h", rsp, v); end
    n_cmp++; if (bsy != 9) begin n_err++; $display("FAIL bp_busy got %0d exp 9", bsy); end
    n_cmp++; if (chain !== d) begin n_err++; $display("FAIL bp_chain got %h exp %h", chain, d); end
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] rsp, exp_rsp; logic [31:0] si; logic rdy, to;
    int bsy, se_n, caps, cap_at, stalls, bad, guard;
    set_chain(8'h96);
    guard = 0;
    while (!req_ready && guard < 100) begin @(negedge clk); guard++; end
    req_valid = 1'b1; req_data = 8'h5A; req_capture = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (scan_se !== 1'b1) begin n_err++; $display("FAIL midrst_pre_se got %b exp 1", scan_se); end
    clr_ = 1'b0;
    #1;
    n_cmp++; if (scan_se !== 1'b0) begin n_err++; $display("FAIL midrst_async_se got %b exp 0", scan_se); end
    n_cmp++;
    if ({busy, req_ready, rsp_valid, rsp_data} !== 11'h0) begin
      n_err++;
      $display("FAIL midrst_outputs got %b exp all zero", {busy, req_ready, rsp_valid, rsp_data});
    end
    @(negedge clk);
    clr_ = 1'b1;
    @(negedge clk);
    exp_rsp = chain;
    do_txn(8'h81, 1'b0, 0, rsp, bsy, si, se_n, caps, cap_at, stalls, bad, rdy, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL midrst_timeout got %b exp 0", to); end
    n_cmp++; if (rsp !== exp_rsp) begin n_err++; $display("FAIL midrst_rsp got %h exp %h", rsp, exp_rsp); end
    n_cmp++; if (si !== 32'h0000_0081) begin n_err++; $display("FAIL midrst_si_seq got %h exp 81", si); end
    n_cmp++; if (chain !== 8'h81) begin n_err++; $display("FAIL midrst_chain got %h exp 81", chain); end
  endtask

  task automatic test_busy_request();
    int acc, hs_cyc, guard;
    int acc_cyc [2];
    acc = 0; hs_cyc = -1; acc_cyc[0] = -1; acc_cyc[1] = -1;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 100) begin @(negedge clk); guard++; end
    rsp_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      req_valid = 1'b1; req_data = 8'($urandom); req_capture = 1'b0;
      if (req_valid && req_ready) begin
        if (acc < 2) acc_cyc[acc] = k;
        acc++;
      end
      if (rsp_valid && rsp_ready && hs_cyc < 0) hs_cyc = k;
      @(negedge clk);
    end
    req_valid = 1'b0;
    guard = 0;
    while (busy && guard < 40) begin @(negedge clk); guard++; end
    rsp_ready = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL busyreq_drain got busy=%b exp 0", busy); end
    n_cmp++; if (acc != 2) begin n_err++; $display("FAIL busyreq_accepts got %0d exp 2", acc); end
    n_cmp++;
    if (!(hs_cyc >= 0 && acc_cyc[1] > hs_cyc)) begin
      n_err++;
      $display("FAIL busyreq_order got second accept %0d handshake %0d exp accept after handshake",
               acc_cyc[1], hs_cyc);
    end
    n_cmp++; if (acc_cyc[1] != 10) begin n_err++; $display("FAIL busyreq_second_cycle got %0d exp 10", acc_cyc[1]); end
  endtask

  task automatic test_random();
    logic [7:0] rsp, v, d, exp_rsp, exp_chain; logic [31:0] si, exp_si; logic c, rdy, to;
    int bsy, se_n, caps, cap_at, stalls, bad, s, exp_busy;
    for (int i = 0; i < 24; i++) begin
      v = 8'($urandom); d = 8'($urandom); c = 1'($urandom_range(0, 1)); s = $urandom_range(0, 3);
      set_chain(v);
      do_txn(d, c, s, rsp, bsy, si, se_n, caps, cap_at, stalls, bad, rdy, to);
      exp_rsp   = c ? ~d : v;
      exp_chain = c ? 8'h00 : d;
      exp_busy  = c ? 18 : 9;
      exp_si    = {24'h0, d};
      n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL rand%0d timeout got %b exp 0", i, to); end
      n_cmp++; if (rsp !== exp_rsp) begin n_err++; $display("FAIL rand%0d rsp got %h exp %h", i, rsp, exp_rsp); end
      n_cmp++; if (si !== exp_si) begin n_err++; $display("FAIL rand%0d si_seq got %h exp %h", i, si, exp_si); end
      n_cmp++; if (se_n != (c ? 16 : 8)) begin n_err++; $display("FAIL rand%0d se_cycles got %0d exp %0d", i, se_n, c ? 16 : 8); end
      n_cmp++; if (caps != int'(c)) begin n_err++; $display("FAIL rand%0d caps got %0d exp %0d", i, caps, c); end
      n_cmp++; if (bsy != exp_busy) begin n_err++; $display("FAIL rand%0d busy got %0d exp %0d", i, bsy, exp_busy); end
      n_cmp++; if (stalls != s || bad != 0) begin n_err++; $display("FAIL rand%0d stall got %0d/%0d exp %0d/0", i, stalls, bad, s); end
      n_cmp++; if (rdy !== 1'b1) begin n_err++; $display("FAIL rand%0d ready_after got %b exp 1", i, rdy); end
      n_cmp++; if (chain !== exp_chain) begin n_err++; $display("FAIL rand%0d chain got %h exp %h", i, chain, exp_chain); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0;
    clr_ = 1'b0; req_valid = 1'b0; req_data = '0; req_capture = 1'b0; rsp_ready = 1'b0;
    chain_load = 1'b0; chain_load_val = '0;
    test_reset();
    test_load_no_capture();
    test_capture();
    test_backpressure();
    test_reset_mid_op();
    test_busy_request();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scan_shift_ctrl.md
SCAN_SHIFT_CTRL -- requirements
Module: scan_shift_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 32, number of scan flops in the driven chain; legal range 2..1024.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port clr_  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  host pattern request valid.
REQ-005 SHALL have port req_ready  output  1  block ready to accept a request.
REQ-006 SHALL have port req_data  input  CHAIN_LEN  pattern to load; bit 0 shifted first.
REQ-007 SHALL have port req_capture  input  1  1 = perform capture and shift-out after load.
REQ-008 SHALL have port scan_se  output  1  scan enable to chain flops.
REQ-009 SHALL have port scan_si  output  1  serial data into the chain head.
REQ-010 SHALL have port scan_so  input  1  serial data from the chain tail.
REQ-011 SHALL have port cap_pulse  output  1  one-cycle functional capture strobe.
REQ-012 SHALL have port rsp_valid  output  1  unload result valid.
REQ-013 SHALL have port rsp_ready  input  1  host accepts result.
REQ-014 SHALL have port rsp_data  output  CHAIN_LEN  unloaded chain contents; first bit out at bit 0.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement states IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, RESP.
REQ-017 SHALL register req_ready high only in IDLE; a request is accepted on a rising edge where req_valid and req_ready are both 1.
REQ-018 SHALL ignore req_valid outside IDLE; no queuing.
REQ-019 SHALL, on acceptance, latch req_data and req_capture, clear the bit counter, and enter SHIFT_IN on the next cycle.
REQ-020 SHALL in SHIFT_IN drive scan_se=1 for exactly CHAIN_LEN cycles, with scan_si = shift-register bit 0; each cycle the shift register becomes {scan_so, sr[CHAIN_LEN-1:1]}.
REQ-021 SHALL use a bit counter of width clog2(CHAIN_LEN); terminal count is CHAIN_LEN-1 with no wrap beyond it.
REQ-022 SHALL, at terminal count in SHIFT_IN, go to CAPTURE when req_capture was latched 1, otherwise to RESP.
REQ-023 SHALL in CAPTURE drive scan_se=0 and cap_pulse=1 for exactly one cycle, then enter SHIFT_OUT.
REQ-024 SHALL in SHIFT_OUT drive scan_se=1 and scan_si=0 for CHAIN_LEN cycles, collecting scan_so as in REQ-020.
REQ-025 SHALL in RESP present rsp_valid=1 and rsp_data equal to the shift register, both held stable until rsp_ready=1.
REQ-026 SHALL return to IDLE the cycle after the rsp handshake; req_ready rises in that IDLE cycle.
REQ-027 SHALL keep busy cycles at CHAIN_LEN+1 without capture and 2*CHAIN_LEN+2 with capture, excluding RESP stall cycles.
REQ-028 SHALL keep scan_se, cap_pulse and scan_si registered (glitch-free); scan_se=0 and scan_si=0 in IDLE and RESP.

Reset
REQ-029 SHALL, on clr_=0 at any time including mid-shift, force state=IDLE immediately; req_ready=0, scan_se=0, scan_si=0, cap_pulse=0, rsp_valid=0, rsp_data=0, busy=0, counter=0.
REQ-030 SHALL raise req_ready on the first clk rising edge after clr_ deasserts.

Structure
REQ-031 SHALL place the state enum and the default CHAIN_LEN constant in shared package scan_ctrl_pkg.
REQ-032 SHALL contain a single sub-module scan_bit_counter (clear, enable, terminal-count flag, async active-low clr_).

Verification (CHAIN_LEN=8; bench models the chain as an 8-bit shift register)
REQ-033 SHALL verify reset: clr_ low for 3 cycles -> all outputs 0; req_ready=1 one edge after release.
REQ-034 SHALL verify load without capture: chain=0xA5, req_data=0x3C, req_capture=0 -> scan_si sequence 0,0,1,1,1,1,0,0 over 8 scan_se cycles; rsp_data=0xA5; chain=0x3C.
REQ-035 SHALL verify capture: chain inverts its contents on cap_pulse, req_data=0x0F, req_capture=1 -> 8 shift cycles, 1 cap_pulse, 8 shift cycles; rsp_data=0xF0; busy high 18 cycles.
REQ-036 SHALL verify backpressure: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid=1, rsp_data stable, req_ready=0 throughout.
REQ-037 SHALL verify reset mid-operation: clr_ low at the 4th SHIFT_IN cycle -> scan_se falls without waiting for clk; the next request 0x81 completes normally with rsp_data equal to the chain contents.
REQ-038 SHALL verify request during busy: req_valid held 1 for 20 cycles -> exactly two acceptances, the second only after the first rsp handshake.
